// File: rtl/wm8731_dac_ctrl_if.sv
// Sample-pair handshake between the audio datapath and the WM8731 DAC sequencer.
// master drives a {left, right} pair with s_valid; slave answers with s_ready.
interface wm8731_dac_ctrl_if #(
  parameter int CH_BITS = 16
);
  logic               s_valid;
  logic               s_ready;
  logic [CH_BITS-1:0] s_left;
  logic [CH_BITS-1:0] s_right;

  modport master (output s_valid, output s_left, output s_right, input s_ready);
  modport slave  (input s_valid, input s_left, input s_right, output s_ready);
endinterface

// File: rtl/wm8731_dac_ctrl.sv
// WM8731 DAC serial sequencer: m_clk/b_clk/dac_lr_clk generation, one-entry sample buffer,
// MSB-first serialisation. Optional macro WM8731_DAC_REPEAT_ON_UNDERRUN_EN resends the last pair on underrun.
module wm8731_dac_ctrl #(
  parameter int MCLK_HALF = 1,
  parameter int BCLK_HALF = 4,
  parameter int CH_BITS   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  wm8731_dac_ctrl_if.slave    aud,
  output logic                m_clk,
  output logic                b_clk,
  output logic                dac_lr_clk,
  output logic                dacdat,
  output logic                underrun,
  output logic                busy
);
  localparam int FW = 2 * CH_BITS;
  localparam int PW = $clog2(2 * BCLK_HALF);
  localparam int BW = (FW > 1) ? $clog2(FW) : 1;
  localparam int MW = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] STOP = 2'd2;

  localparam logic [PW-1:0] PH_LAST  = PW'(2 * BCLK_HALF - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FW - 1);

  logic [1:0]    state_reg, state_next;
  logic [PW-1:0] ph_reg, ph_next;
  logic [BW-1:0] bit_reg, bit_next;
  logic [MW-1:0] mclk_cnt_reg;
  logic          m_clk_reg;
  logic          buf_full_reg, buf_full_next;
  logic [FW-1:0] buf_data_reg;
  logic [FW-1:0] shreg_reg, shreg_next;
  logic          b_clk_reg, b_clk_next;
  logic          lr_reg, lr_next;
  logic          dacdat_reg, dacdat_next;
  logic          underrun_reg, underrun_next;
  logic          busy_reg;
  logic          ready_reg;
  logic          accept, frame_start, consume;
  logic [FW-1:0] load_word;
`ifdef WM8731_DAC_REPEAT_ON_UNDERRUN_EN
  logic [FW-1:0] last_reg;
`endif

  assign accept = aud.s_valid && ready_reg;

  always_comb begin
    state_next  = state_reg;
    ph_next     = ph_reg;
    bit_next    = bit_reg;
    frame_start = 1'b0;
    case (state_reg)
      RUN, STOP: begin
        if (ph_reg == PH_LAST) begin
          ph_next = '0;
          if (bit_reg == BIT_LAST) begin
            // Frame boundary: either roll straight into the next frame or park in IDLE.
            bit_next = '0;
            if (enable) begin
              state_next  = RUN;
              frame_start = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end else begin
            bit_next   = bit_reg + BW'(1);
            state_next = enable ? RUN : STOP;
          end
        end else begin
          ph_next    = ph_reg + PW'(1);
          state_next = enable ? RUN : STOP;
        end
      end
      default: begin
        ph_next  = '0;
        bit_next = '0;
        if (enable) begin
          state_next  = RUN;
          frame_start = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    consume       = 1'b0;
    load_word     = '0;
    underrun_next = underrun_reg;
    shreg_next    = shreg_reg;
    dacdat_next   = dacdat_reg;
    if (frame_start) begin
      if (buf_full_reg) begin
        load_word = buf_data_reg;
        consume   = 1'b1;
      end else begin
        underrun_next = 1'b1;
`ifdef WM8731_DAC_REPEAT_ON_UNDERRUN_EN
        load_word = last_reg;
`endif
      end
      // The MSB goes straight to the pin; the register keeps the remaining bits.
      shreg_next  = load_word << 1;
      dacdat_next = load_word[FW-1];
    end else if (state_next == IDLE) begin
      shreg_next  = '0;
      dacdat_next = 1'b0;
    end else if (ph_next == '0) begin
      dacdat_next = shreg_reg[FW-1];
      shreg_next  = shreg_reg << 1;
    end
    buf_full_next = consume ? 1'b0 : (accept ? 1'b1 : buf_full_reg);
    b_clk_next    = (state_next != IDLE) && (ph_next < PW'(BCLK_HALF));
    lr_next       = (state_next != IDLE) && (bit_next < BW'(CH_BITS));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      ph_reg       <= '0;
      bit_reg      <= '0;
      buf_full_reg <= 1'b0;
      buf_data_reg <= '0;
      shreg_reg    <= '0;
      b_clk_reg    <= 1'b0;
      lr_reg       <= 1'b0;
      dacdat_reg   <= 1'b0;
      underrun_reg <= 1'b0;
      busy_reg     <= 1'b0;
      ready_reg    <= 1'b1;
    end else begin
      state_reg    <= state_next;
      ph_reg       <= ph_next;
      bit_reg      <= bit_next;
      buf_full_reg <= buf_full_next;
      if (accept) begin
        buf_data_reg <= {aud.s_left, aud.s_right};
      end
      shreg_reg    <= shreg_next;
      b_clk_reg    <= b_clk_next;
      lr_reg       <= lr_next;
      dacdat_reg   <= dacdat_next;
      underrun_reg <= underrun_next;
      busy_reg     <= (state_next != IDLE);
      ready_reg    <= !buf_full_next;
    end
  end

`ifdef WM8731_DAC_REPEAT_ON_UNDERRUN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      last_reg <= '0;
    end else if (consume) begin
      last_reg <= buf_data_reg;
    end
  end
`endif

  // m_clk free-runs in every state so the codec always has a master clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      mclk_cnt_reg <= '0;
      m_clk_reg    <= 1'b0;
    end else if (mclk_cnt_reg == MW'(MCLK_HALF - 1)) begin
      mclk_cnt_reg <= '0;
      m_clk_reg    <= !m_clk_reg;
    end else begin
      mclk_cnt_reg <= mclk_cnt_reg + MW'(1);
    end
  end

  assign aud.s_ready = ready_reg;
  assign m_clk       = m_clk_reg;
  assign b_clk       = b_clk_reg;
  assign dac_lr_clk  = lr_reg;
  assign dacdat      = dacdat_reg;
  assign underrun    = underrun_reg;
  assign busy        = busy_reg;
endmodule

// File: tb/tb_wm8731_dac_ctrl.sv
// Self-checking bench for wm8731_dac_ctrl: table of sample pairs, expected-frame scoreboard,
// and a DAC model that captures dacdat on b_clk falling edges.
module tb_wm8731_dac_ctrl;
  logic clk;
  logic reset;
  logic enable;
  logic m_clk, b_clk, dac_lr_clk, dacdat, underrun, busy;

  wm8731_dac_ctrl_if #(.CH_BITS(16)) aud ();

  wm8731_dac_ctrl #(.MCLK_HALF(1), .BCLK_HALF(4), .CH_BITS(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .aud        (aud),
    .m_clk      (m_clk),
    .b_clk      (b_clk),
    .dac_lr_clk (dac_lr_clk),
    .dacdat     (dacdat),
    .underrun   (underrun),
    .busy       (busy)
  );

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [5];
  logic [31:0] exp_q [$];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  // DAC functional model state
  int          nb = 0;
  int          frames_done = 0;
  int          cyc = 0;
  int          last_rise = 0;
  int          last_frame = 0;
  bit          have_rise = 0;
  bit          have_frame = 0;
  bit          prev_b = 0;
  bit          prev_lr = 0;
  logic [31:0] word = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_frames(input int n);
    for (int k = 0; k < 5000 && frames_done < n; k++) tick();
    check("frames_reached", 32'(frames_done >= n), 32'd1);
  endtask

  task automatic wait_bits(input int n);
    for (int k = 0; k < 2000 && nb != n; k++) tick();
    check("bit_reached", 32'(nb), 32'(n));
  endtask

  task automatic send(input vec_t v);
    for (int k = 0; k < 600 && !aud.s_ready; k++) tick();
    check("s_ready_wait", 32'(aud.s_ready), 32'd1);
    aud.s_valid = 1'b1;
    aud.s_left  = v.l;
    aud.s_right = v.r;
    tick();
    aud.s_valid = 1'b0;
    exp_q.push_back(v.exp);
    $display("send %h/%h", v.l, v.r);
    check("s_ready_full", 32'(aud.s_ready), 32'd0);
  endtask

  // DAC model: one frame = 32 bits captured on b_clk falls, compared with the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        nb = 0; word = '0; have_rise = 0; have_frame = 0; prev_b = 0; prev_lr = 0;
      end else begin
        cyc++;
        if (b_clk && !prev_b) begin
          if (have_rise) check("bclk_period", 32'(cyc - last_rise), 32'd8);
          last_rise = cyc;
          have_rise = 1;
          if (dac_lr_clk && !prev_lr) begin
            if (have_frame) check("frame_period", 32'(cyc - last_frame), 32'd256);
            last_frame = cyc;
            have_frame = 1;
          end
        end
        if (!b_clk && prev_b) begin
          check("lr_clk", 32'(dac_lr_clk), 32'(nb < 16));
          word = {word[30:0], dacdat};
          nb++;
          if (nb == 32) begin
            $display("frame %0d: %h", frames_done + 1, word);
            if (exp_q.size() == 0) begin
              total_cnt++;
              $display("FAIL frame_extra: got %h required none", word);
            end else begin
              check("frame", word, exp_q.pop_front());
            end
            nb = 0;
            frames_done++;
          end
        end
        if (!busy) begin
          have_rise = 0;
          have_frame = 0;
        end
        prev_b  = b_clk;
        prev_lr = dac_lr_clk;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic        prev_m;
    logic [31:0] under_exp;
    vecs[0] = '{16'hA5C3, 16'h0F1E, 32'hA5C30F1E};
    vecs[1] = '{16'h0001, 16'h8000, 32'h00018000};
    vecs[2] = '{16'hFFFF, 16'h0000, 32'hFFFF0000};
    vecs[3] = '{16'h1234, 16'h5678, 32'h12345678};
    vecs[4] = '{16'h7FFF, 16'h8001, 32'h7FFF8001};
`ifdef WM8731_DAC_REPEAT_ON_UNDERRUN_EN
    under_exp = 32'h7FFF8001;
`else
    under_exp = 32'h00000000;
`endif

    reset = 1'b1; enable = 1'b0;
    aud.s_valid = 1'b0; aud.s_left = '0; aud.s_right = '0;
    tick(); tick();
    check("reset_state", {25'd0, m_clk, b_clk, dac_lr_clk, dacdat, busy, underrun, aud.s_ready},
          32'h00000001);
    reset = 1'b0;

    // Idle with enable low: only m_clk moves.
    prev_m = m_clk;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("mclk_toggle", 32'(m_clk), 32'(!prev_m));
      check("idle_outputs", {26'd0, b_clk, dac_lr_clk, dacdat, busy, underrun, aud.s_ready},
            32'h00000001);
      prev_m = m_clk;
    end

    // Pre-load, then start: first frame-start edge.
    send(vecs[0]);
    check("preload_idle_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    tick();
    check("start_outputs", {27'd0, busy, b_clk, dac_lr_clk, dacdat, aud.s_ready}, 32'h0000001F);

    // Stream four pairs back to back.
    for (int i = 1; i < 5; i++) send(vecs[i]);
    exp_q.push_back(under_exp);
    wait_frames(5);
    check("no_underrun_yet", 32'(underrun), 32'd0);
    repeat (10) tick();
    check("underrun_set", 32'(underrun), 32'd1);
    check("ready_after_underrun", 32'(aud.s_ready), 32'd1);

    // Drop enable at bit 5; frame completes, then IDLE with buffer kept.
    send(vecs[1]);
    wait_frames(6);
    wait_bits(5);
    enable = 1'b0;
    send(vecs[2]);
    wait_frames(7);
    repeat (3) tick();
    check("stop_busy_last", 32'(busy), 32'd1);
    tick();
    check("stop_idle", {28'd0, busy, b_clk, dac_lr_clk, dacdat}, 32'd0);
    repeat (5) tick();
    check("idle_buffer_kept", 32'(aud.s_ready), 32'd0);

    // Restart, then drop and re-raise enable inside a frame: no gap expected.
    enable = 1'b1;
    send(vecs[3]);
    wait_bits(5);
    enable = 1'b0;
    repeat (50) tick();
    check("stop_still_busy", 32'(busy), 32'd1);
    enable = 1'b1;
    send(vecs[4]);
    wait_frames(8);

    // Reset in the middle of frame 9 with the buffer full.
    wait_bits(10);
    check("pre_reset_flags", {30'd0, underrun, aud.s_ready}, 32'h00000002);
    check("queue_depth", 32'(exp_q.size()), 32'd2);
    reset = 1'b1;
    tick();
    check("mid_frame_reset", {26'd0, b_clk, dac_lr_clk, dacdat, busy, underrun, aud.s_ready},
          32'h00000001);
    exp_q.delete();
    reset = 1'b0;
    enable = 1'b0;
    repeat (4) tick();
    check("post_reset_idle", {27'd0, b_clk, dac_lr_clk, busy, underrun, aud.s_ready},
          32'h00000001);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
